// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM states, reset-cause codes,
// active-low reset levels and the delay-counter helper.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_BUS_WAIT,
    ST_CPU_WAIT,
    ST_IO_WAIT,
    ST_RUN,
    ST_HOLD
  } state_t;

  localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
  localparam logic [1:0] RST_CAUSE_SOFT = 2'b01;
  localparam logic [1:0] RST_CAUSE_WDT  = 2'b10;

  // Active-low domain reset levels.
  localparam logic RST_ASSERT  = 1'b0;
  localparam logic RST_RELEASE = 1'b1;

  localparam int CNT_W = 8;

  // Terminal count for a wait of dly cycles (counter starts at 0).
  function automatic logic [CNT_W-1:0] last_count(input int dly);
    return CNT_W'(dly - 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer; reusable in any clock domain.
module rst_sync
  import reset_seq_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_n
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], RST_RELEASE};
    end
  end

  assign sync_n = chain[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: releases bus, CPU and I/O reset domains in order after the
// synchronized chip reset or a soft/watchdog request, and records the cause.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BUS_DLY     = 16,
  parameter int CPU_DLY     = 16,
  parameter int IO_DLY      = 16,
  parameter int SOFT_HOLD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_rst_req,
  input  logic       wdt_rst_req,
  output logic       bus_reset,
  output logic       cpu_reset,
  output logic       io_reset,
  output logic       sys_ready,
  output logic [1:0] rst_cause
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_n;

  rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk   (clk),
    .rst_n (reset),
    .sync_n(sync_n)
  );

  // NOTE: state, counter and outputs are flops, so every assignment here is
  // non-blocking; blocking ones would let later branches see updated values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SYNC;
      cnt       <= '0;
      bus_reset <= RST_ASSERT;
      cpu_reset <= RST_ASSERT;
      io_reset  <= RST_ASSERT;
      sys_ready <= 1'b0;
      rst_cause <= RST_CAUSE_POR;
    end else begin
      case (state)
        ST_SYNC: begin
          if (sync_n) begin
            state <= ST_BUS_WAIT;
            cnt   <= '0;
          end
        end

        ST_BUS_WAIT: begin
          if (cnt == last_count(BUS_DLY)) begin
            bus_reset <= RST_RELEASE;
            state     <= ST_CPU_WAIT;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_CPU_WAIT: begin
          if (cnt == last_count(CPU_DLY)) begin
            cpu_reset <= RST_RELEASE;
            state     <= ST_IO_WAIT;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_IO_WAIT: begin
          if (cnt == last_count(IO_DLY)) begin
            io_reset  <= RST_RELEASE;
            sys_ready <= 1'b1;
            state     <= ST_RUN;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        // Requests are only honoured here; elsewhere they are dropped.
        ST_RUN: begin
          if (wdt_rst_req || soft_rst_req) begin
            bus_reset <= RST_ASSERT;
            cpu_reset <= RST_ASSERT;
            io_reset  <= RST_ASSERT;
            sys_ready <= 1'b0;
            rst_cause <= wdt_rst_req ? RST_CAUSE_WDT : RST_CAUSE_SOFT;
            state     <= ST_HOLD;
            cnt       <= '0;
          end
        end

        ST_HOLD: begin
          if (cnt == last_count(SOFT_HOLD)) begin
            state <= ST_BUS_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state <= ST_SYNC;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: power-on, soft/watchdog sequences, ignored
// requests, async reset mid-sequence and a minimum-delay parameter corner.
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       wdt_rst_req = 1'b0;
  logic       bus_reset, cpu_reset, io_reset, sys_ready;
  logic [1:0] rst_cause;

  logic       req_off = 1'b0;
  logic       bus_reset_c, cpu_reset_c, io_reset_c, sys_ready_c;
  logic [1:0] rst_cause_c;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  logic [3:0] obs, obs_c;
  assign obs   = {bus_reset, cpu_reset, io_reset, sys_ready};
  assign obs_c = {bus_reset_c, cpu_reset_c, io_reset_c, sys_ready_c};

  always #5 clk = ~clk;

  reset_seq dut (
    .clk         (clk),
    .reset       (reset),
    .soft_rst_req(soft_rst_req),
    .wdt_rst_req (wdt_rst_req),
    .bus_reset   (bus_reset),
    .cpu_reset   (cpu_reset),
    .io_reset    (io_reset),
    .sys_ready   (sys_ready),
    .rst_cause   (rst_cause)
  );

  reset_seq #(
    .SYNC_STAGES(3),
    .BUS_DLY    (1),
    .CPU_DLY    (1),
    .IO_DLY     (1),
    .SOFT_HOLD  (1)
  ) dut_c (
    .clk         (clk),
    .reset       (reset),
    .soft_rst_req(req_off),
    .wdt_rst_req (req_off),
    .bus_reset   (bus_reset_c),
    .cpu_reset   (cpu_reset_c),
    .io_reset    (io_reset_c),
    .sys_ready   (sys_ready_c),
    .rst_cause   (rst_cause_c)
  );

  // Expected {bus, cpu, io, sys_ready} given the edges each domain rises at.
  function automatic logic [3:0] exp_vec(input int n, input int b, input int c, input int i);
    return {logic'(n >= b), logic'(n >= c), logic'(n >= i), logic'(n >= i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Full power-on sequence after a reset release; optional watchdog pulse.
  task automatic por_sequence(input string name, input int wdt_edge, input bit corner);
    logic [3:0] exp;
    for (int n = 1; n <= 60; n++) begin
      if (n == wdt_edge) wdt_rst_req = 1'b1;
      tick();
      wdt_rst_req = 1'b0;
      exp = exp_vec(n, 19, 35, 51);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL %s edge %0d: outputs %b, expected %b", name, n, obs, exp);
      end
      if (corner && n <= 10) begin
        exp = exp_vec(n, 5, 6, 7);
        tests++;
        if (obs_c !== exp) begin
          fails++;
          $display("FAIL corner edge %0d: outputs %b, expected %b", n, obs_c, exp);
        end
      end
    end
    tests++;
    if (rst_cause !== 2'b00) begin
      fails++;
      $display("FAIL %s cause: got %b, expected 00", name, rst_cause);
    end
  endtask

  // Request sampled at edge e, then the full re-release sequence.
  task automatic req_sequence(input string name, input int e, input logic s, input logic w,
                              input logic [1:0] cause);
    logic [3:0] exp;
    run_to(e - 1);
    soft_rst_req = s;
    wdt_rst_req  = w;
    tick();
    soft_rst_req = 1'b0;
    wdt_rst_req  = 1'b0;
    for (int n = e; n <= e + 60; n++) begin
      if (n > e) tick();
      exp = exp_vec(n, e + 24, e + 40, e + 56);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL %s edge %0d: outputs %b, expected %b", name, n, obs, exp);
      end
    end
    tests++;
    if (rst_cause !== cause) begin
      fails++;
      $display("FAIL %s cause: got %b, expected %b", name, rst_cause, cause);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs !== 4'b0000 || rst_cause !== 2'b00) begin
      fails++;
      $display("FAIL reset_values: outputs %b cause %b, expected 0000 00", obs, rst_cause);
    end
    tests++;
    if (obs_c !== 4'b0000 || rst_cause_c !== 2'b00) begin
      fails++;
      $display("FAIL reset_values_corner: outputs %b cause %b, expected 0000 00", obs_c, rst_cause_c);
    end
  endtask

  task automatic test_power_on();
    release_reset();
    por_sequence("power_on", -1, 1'b1);
  endtask

  task automatic test_soft();
    req_sequence("soft", 100, 1'b1, 1'b0, 2'b01);
  endtask

  task automatic test_both();
    req_sequence("both", 170, 1'b1, 1'b1, 2'b10);
  endtask

  // Request held across the return to RUN fires again on the first RUN edge.
  task automatic test_back_to_back();
    run_to(239);
    soft_rst_req = 1'b1;
    run_to(296);
    tests++;
    if (obs !== 4'b1111) begin
      fails++;
      $display("FAIL back_to_back edge 296: outputs %b, expected 1111", obs);
    end
    tick();
    tests++;
    if (obs !== 4'b0000 || rst_cause !== 2'b01) begin
      fails++;
      $display("FAIL back_to_back edge 297: outputs %b cause %b, expected 0000 01", obs, rst_cause);
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic test_ignored();
    reset = 1'b0;
    #1;
    tests++;
    if (obs !== 4'b0000 || rst_cause !== 2'b00) begin
      fails++;
      $display("FAIL async_clear_cause: outputs %b cause %b, expected 0000 00", obs, rst_cause);
    end
    release_reset();
    por_sequence("wdt_ignored", 25, 1'b0);
  endtask

  task automatic test_async_mid();
    reset = 1'b0;
    release_reset();
    run_to(30);
    #2;
    tests++;
    if (bus_reset !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre_drop: bus_reset %b, expected 1", bus_reset);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (obs !== 4'b0000) begin
      fails++;
      $display("FAIL mid_async_drop: outputs %b, expected 0000", obs);
    end
    release_reset();
    por_sequence("async_mid", -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft();
    test_both();
    test_back_to_back();
    test_ignored();
    test_async_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
